// File: rtl/vga_frame_reader.sv
// VGA timing generator and frame-buffer reader: fetches 32-bit words, shows 4 gray pixels per word.
// Outputs for counter position (h,v) are registered 2 pixel ticks after the address tick; no stall, memory must answer in one clock.
module vga_frame_reader #(
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter int unsigned IMG_W     = 256,
   parameter int unsigned IMG_H     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] vga_rd,
   output logic [31:0] vga_address,
   output logic        vga_clk,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic        vga_sync_n,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        frame_start
);
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);
   localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS     = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE     = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_IMG    = HW'(IMG_W);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS     = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE     = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_IMG    = VW'(IMG_H);

   logic [DW-1:0] div_q, div_d;
   logic          tick;
   logic          vga_clk_q, vga_clk_d;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          fs_q, fs_d;
   logic [31:0]   addr_q, addr_d;
   logic          in_img0, fetch0, vis0, hs0, vs0;

   logic          s1_fetch_q, s1_img_q, s1_vis_q, s1_hs_q, s1_vs_q;
   logic [1:0]    s1_sel_q;
   logic          s2_img_q, s2_vis_q, s2_hs_q, s2_vs_q;
   logic [1:0]    s2_sel_q;
   logic [31:0]   word_q;
   logic [7:0]    gray;
   logic          hs_q, vs_q, blank_q;
   logic [7:0]    gray_q;

   always_comb begin
      tick    = (div_q == DIV_LAST);
      div_d   = tick ? '0 : div_q + 1'b1;
      h_d     = h_q;
      v_d     = v_q;
      fs_d    = 1'b0;
      if (tick) begin
         h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
         if (h_q == H_LAST) begin
            v_d  = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            fs_d = (v_q == V_LAST);
         end
      end
      in_img0 = (h_q < H_IMG) && (v_q < V_IMG);
      fetch0  = in_img0 && (h_q[1:0] == 2'b00);
      vis0    = (h_q < H_ACT) && (v_q < V_ACT);
      hs0     = (h_q >= H_SS) && (h_q < H_SE);
      vs0     = (v_q >= V_SS) && (v_q < V_SE);
      addr_d  = addr_q;
      if (tick && fetch0)
         addr_d = BASE_ADDR + (32'(v_q) * IMG_W) + 32'(h_q);
      gray    = word_q[{s2_sel_q, 3'b000} +: 8];
   end

   // With one system clock per tick the pixel clock is simply held high.
   generate
      if (CLK_DIV == 1) begin : g_clk_tick
         assign vga_clk_d = 1'b1;
      end else begin : g_clk_div
         assign vga_clk_d = (div_d >= DW'(CLK_DIV / 2));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q      <= '0;
         vga_clk_q  <= 1'b0;
         h_q        <= '0;
         v_q        <= '0;
         fs_q       <= 1'b0;
         addr_q     <= BASE_ADDR;
         s1_fetch_q <= 1'b0;
         s1_img_q   <= 1'b0;
         s1_vis_q   <= 1'b0;
         s1_hs_q    <= 1'b0;
         s1_vs_q    <= 1'b0;
         s1_sel_q   <= 2'b00;
         s2_img_q   <= 1'b0;
         s2_vis_q   <= 1'b0;
         s2_hs_q    <= 1'b0;
         s2_vs_q    <= 1'b0;
         s2_sel_q   <= 2'b00;
         word_q     <= '0;
         hs_q       <= 1'b1;
         vs_q       <= 1'b1;
         blank_q    <= 1'b0;
         gray_q     <= 8'h00;
      end else begin
         div_q     <= div_d;
         vga_clk_q <= vga_clk_d;
         h_q       <= h_d;
         v_q       <= v_d;
         fs_q      <= fs_d;
         addr_q    <= addr_d;
         if (tick) begin
            s1_fetch_q <= fetch0;
            s1_img_q   <= in_img0;
            s1_vis_q   <= vis0;
            s1_hs_q    <= hs0;
            s1_vs_q    <= vs0;
            s1_sel_q   <= h_q[1:0];
            // The next word lands on the same tick that the last byte of the old one is emitted.
            if (s1_fetch_q)
               word_q <= vga_rd;
            s2_img_q   <= s1_img_q;
            s2_vis_q   <= s1_vis_q;
            s2_hs_q    <= s1_hs_q;
            s2_vs_q    <= s1_vs_q;
            s2_sel_q   <= s1_sel_q;
            hs_q       <= ~s2_hs_q;
            vs_q       <= ~s2_vs_q;
            blank_q    <= s2_vis_q;
            gray_q     <= (s2_img_q && s2_vis_q) ? gray : 8'h00;
         end
      end
   end

   assign vga_address = addr_q;
   assign vga_clk     = vga_clk_q;
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_blank_n = blank_q;
   assign vga_sync_n  = 1'b0;
   assign vga_r       = gray_q;
   assign vga_g       = gray_q;
   assign vga_b       = gray_q;
   assign frame_start = fs_q;
endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Read-side master for the memory block's dedicated VGA port; the processor writes the frame buffer through the data port.
- Generates 640x480@60 Hz VGA timing from the system clock.
- Fetches 32-bit frame-buffer words over `vga_address`/`vga_rd` and unpacks four 8-bit grayscale pixels per word.
- Drives sync, blank and RGB to the VGA DAC. Sits beside the memory instance in the FIR filter top level.

Parameters:
- CLK_DIV, 2, system clocks per pixel tick (50 MHz -> 25 MHz); legal values >= 1.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in ticks.
- H_SYNC, 96, hsync pulse width, in ticks.
- H_BP, 48, horizontal back porch, in ticks.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync pulse width, in lines.
- V_BP, 33, vertical back porch, in lines.
- IMG_W, 256, image width in pixels; multiple of 4, <= H_ACTIVE.
- IMG_H, 256, image height in lines; <= V_ACTIVE.
- BASE_ADDR, 32'h0000_1000, byte address of pixel (0,0) in memory.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset.
- vga_rd, input, 32, word read from memory at `vga_address`; combinational, settles within one system clock.
- vga_address, output, 32, registered byte address, word aligned.
- vga_clk, output, 1, pixel clock to DAC; high for the system cycle carrying a pixel tick when CLK_DIV=1, else a divided square wave.
- vga_hs, output, 1, horizontal sync, active low.
- vga_vs, output, 1, vertical sync, active low.
- vga_blank_n, output, 1, 1 while the output pixel is in the visible area.
- vga_sync_n, output, 1, tied 0.
- vga_r, output, 8, red.
- vga_g, output, 8, green.
- vga_b, output, 8, blue.
- frame_start, output, 1, one-system-clock pulse on the tick where the counters wrap to (0,0).

Behaviour:
- Everything is decided by this spec (one clock, rst async active-low).
- Reset (rst=0):
  - Tick divider, h_cnt and v_cnt go to 0; pipeline registers are cleared.
  - vga_address=BASE_ADDR; vga_hs=1, vga_vs=1, vga_blank_n=0, RGB=0, frame_start=0, vga_clk=0.
  - Reset asserted mid-frame aborts the frame. After release, the first tick restarts at (0,0) and the next frame_start occurs one full frame later.
- Tick: a divider counts 0..CLK_DIV-1; a tick fires on the cycle the count equals CLK_DIV-1. All state below changes only on ticks.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800.
  - On the h_cnt wrap, v_cnt increments, range 0..V_TOTAL-1 with V_TOTAL=525.
  - Both wrap to 0 simultaneously at the end of a frame, and frame_start pulses.
- Stage 0 (tick with counters at h,v):
  - in_img = (h<IMG_W)&&(v<IMG_H).
  - If in_img and h[1:0]==0: vga_address <= BASE_ADDR + v*IMG_W + h. This is a byte address: 4 pixels/word, row stride IMG_W bytes, arithmetic in 32 bits, no wrap checks.
  - Otherwise vga_address holds its value.
- Stage 1 (next tick): if the stage-0 pixel started a word, word_reg <= vga_rd. Also capture in_img, h[1:0], visible=(h<H_ACTIVE && v<V_ACTIVE), and raw syncs.
- Stage 2 (next tick):
  - gray = word_reg byte h[1:0], little-endian: byte0=[7:0] is the leftmost pixel.
  - vga_r=vga_g=vga_b = in_img ? gray : 0 (0 also when not visible).
  - vga_blank_n=visible.
  - vga_hs=0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vga_vs=0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
- Latency: exactly 2 pixel ticks from counters at (h,v) to all outputs for (h,v). Syncs, blank and RGB stay mutually aligned.
- Word reuse: word_reg for pixel h is not overwritten before pixel h+3 is output. The new word is latched on the same tick pixel h+3 is emitted, and nonblocking order guarantees the old value is used.
- The memory port is read-only from this block; there is no handshake and no stall. The memory must answer within one tick.
- Boundaries:
  - Last pixel of the image row (h=IMG_W-1) is shown; h=IMG_W outputs 0.
  - Line IMG_H-1 is fetched; line IMG_H is black.
  - Blanking intervals issue no new addresses.

Test Plan:
- CLK_DIV=2, release reset -> frame_start period 840000 clks; vga_hs low for 192 clks per 1600-clk line; vga_vs low for exactly 2 lines (v=490,491, shifted 2 ticks).
- Memory model returns 32'h44332211 at BASE_ADDR, 32'h88776655 at BASE_ADDR+4 -> pixels (0..7,0) output gray 11,22,33,44,55,66,77,88 on consecutive ticks, starting 2 ticks after h=0. vga_address sequence 0x1000, 0x1004, ...
- Row stride: word 32'hA0A0A0A0 at BASE_ADDR+256 -> pixel (0,1) outputs A0; vga_address at (0,1) equals 0x1100.
- Pixels (256,0), (0,256) and (639,479) -> RGB=0 with vga_blank_n=1. Pixel (640,0) -> vga_blank_n=0, RGB=0.
- Assert rst at (300,100) for 3 clks -> all outputs return to reset values immediately (async). After release, next frame_start after 420000 ticks; vga_address=0x1000 at restart.
- CLK_DIV=1 -> same sequences at 1 tick/clk; vga_hs low for 96 consecutive clks.
